// File: rtl/glue_pkg.sv
// Shared types and defaults for the 68000 bus cycle controller.
// State encoding and default wait-state timing live here.
package glue_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WAIT,
        ST_INT,
        ST_ACK,
        ST_BERR
    } state_e;

    localparam int RAM_WAIT_DEF     = 1;
    localparam int ROM_WAIT_DEF     = 3;
    localparam int IO_WAIT_DEF      = 7;
    localparam int BERR_TIMEOUT_DEF = 255;

    localparam int WCNT_W = 8;
    localparam int TCNT_W = 16;

    function automatic logic one_hot8(input logic [7:0] v);
        return $countones(v) == 1;
    endfunction

endpackage

// File: rtl/sync2.sv
// Two-flop synchroniser for one asynchronous strobe.
// Resets to the negated level given by RST_VAL.
module sync2 #(
    parameter logic RST_VAL = 1'b1
) (
    input  logic sysclk,
    input  logic sysrst,
    input  logic d,
    output logic q
);

    logic meta_q;

    always_ff @(posedge sysclk or posedge sysrst) begin
        if (sysrst) begin
            meta_q <= RST_VAL;
            q      <= RST_VAL;
        end else begin
            meta_q <= d;
            q      <= meta_q;
        end
    end

endmodule

// File: rtl/bus_cycle_ctrl.sv
// 68000 bus cycle controller: wait states, internal targets,
// DTACK/BERR termination, all outputs registered on sysclk.
module bus_cycle_ctrl
    import glue_pkg::*;
#(
    parameter int RAM_WAIT     = RAM_WAIT_DEF,
    parameter int ROM_WAIT     = ROM_WAIT_DEF,
    parameter int IO_WAIT      = IO_WAIT_DEF,
    parameter int BERR_TIMEOUT = BERR_TIMEOUT_DEF
) (
    input  logic sysclk,
    input  logic sysrst,
    input  logic as_n,
    input  logic uds_n,
    input  logic lds_n,
    input  logic w_n,
    input  logic csram1,
    input  logic csram2,
    input  logic csrom,
    input  logic csio,
    input  logic csgfx,
    input  logic csctrl,
    input  logic cspgtbl,
    input  logic csunmap,
    input  logic io_ready,
    output logic re_n,
    output logic we_n,
    output logic dtack_n,
    output logic berr_n,
    output logic int_rd,
    output logic int_wr,
    output logic busy
);

    localparam logic [WCNT_W-1:0] RAM_W = WCNT_W'(RAM_WAIT);
    localparam logic [WCNT_W-1:0] ROM_W = WCNT_W'(ROM_WAIT);
    localparam logic [WCNT_W-1:0] IO_W  = WCNT_W'(IO_WAIT);
    localparam logic [TCNT_W-1:0] TMO   = TCNT_W'(BERR_TIMEOUT);

    logic as_sn, uds_sn, lds_sn, w_sn;
    logic as_s, ds_s, w_s;

    sync2 u_sync_as (
        .sysclk (sysclk),
        .sysrst (sysrst),
        .d      (as_n),
        .q      (as_sn)
    );

    sync2 u_sync_uds (
        .sysclk (sysclk),
        .sysrst (sysrst),
        .d      (uds_n),
        .q      (uds_sn)
    );

    sync2 u_sync_lds (
        .sysclk (sysclk),
        .sysrst (sysrst),
        .d      (lds_n),
        .q      (lds_sn)
    );

    sync2 u_sync_w (
        .sysclk (sysclk),
        .sysrst (sysrst),
        .d      (w_n),
        .q      (w_sn)
    );

    assign as_s = ~as_sn;
    assign ds_s = ~uds_sn | ~lds_sn;
    assign w_s  = w_sn;

    logic [7:0] sel;
    logic dec_berr, dec_int;
    logic [WCNT_W-1:0] wload;

    assign sel = {csunmap, cspgtbl, csctrl, csgfx,
                  csio, csrom, csram2, csram1};

    always_comb begin
        dec_berr = ~one_hot8(sel) | csunmap | (~w_s & csrom);
        dec_int  = csgfx | csctrl | cspgtbl;
        wload    = RAM_W;
        if (csrom) begin
            wload = ROM_W;
        end else if (csio) begin
            wload = IO_W;
        end
    end

    state_e            state_q;
    logic [WCNT_W-1:0] wcnt_q, wcnt_d;
    logic [TCNT_W-1:0] tcnt_q, tcnt_d;
    logic              is_io_q;
    logic              armed_q;
    logic [1:0]        vld_q;
    logic              re_n_q, we_n_q, dtack_n_q, berr_n_q;
    logic              int_rd_q, int_wr_q, busy_q;
    logic              wait_done, tmo_hit;

    assign wcnt_d    = (wcnt_q == '0) ? '0 : wcnt_q - WCNT_W'(1);
    assign tcnt_d    = tcnt_q + TCNT_W'(1);
    assign wait_done = (wcnt_q == '0) & (~is_io_q | io_ready);
    assign tmo_hit   = tcnt_d >= TMO;

    // vld_q tracks when the synchroniser holds real samples again after
    // reset, so a strobe held through reset cannot arm a new cycle.
    always_ff @(posedge sysclk or posedge sysrst) begin
        if (sysrst) begin
            state_q   <= ST_IDLE;
            wcnt_q    <= '0;
            tcnt_q    <= '0;
            is_io_q   <= 1'b0;
            armed_q   <= 1'b0;
            vld_q     <= 2'b00;
            re_n_q    <= 1'b1;
            we_n_q    <= 1'b1;
            dtack_n_q <= 1'b1;
            berr_n_q  <= 1'b1;
            int_rd_q  <= 1'b0;
            int_wr_q  <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            vld_q    <= {vld_q[0], 1'b1};
            int_rd_q <= 1'b0;
            int_wr_q <= 1'b0;
            unique case (state_q)
                ST_IDLE: begin
                    if (vld_q[1] && !as_s) begin
                        armed_q <= 1'b1;
                    end
                    if (armed_q && as_s && ds_s) begin
                        armed_q <= 1'b0;
                        busy_q  <= 1'b1;
                        if (dec_berr) begin
                            state_q  <= ST_BERR;
                            berr_n_q <= 1'b0;
                        end else if (dec_int) begin
                            state_q  <= ST_INT;
                            int_rd_q <= w_s;
                            int_wr_q <= ~w_s;
                        end else begin
                            state_q <= ST_WAIT;
                            wcnt_q  <= wload;
                            tcnt_q  <= '0;
                            is_io_q <= csio;
                            re_n_q  <= ~w_s;
                            we_n_q  <= w_s;
                        end
                    end
                end
                ST_WAIT: begin
                    wcnt_q <= wcnt_d;
                    tcnt_q <= tcnt_d;
                    if (!as_s) begin
                        state_q <= ST_IDLE;
                        re_n_q  <= 1'b1;
                        we_n_q  <= 1'b1;
                        busy_q  <= 1'b0;
                    end else if (wait_done) begin
                        state_q   <= ST_ACK;
                        dtack_n_q <= 1'b0;
                    end else if (tmo_hit) begin
                        state_q  <= ST_BERR;
                        berr_n_q <= 1'b0;
                        re_n_q   <= 1'b1;
                        we_n_q   <= 1'b1;
                    end
                end
                ST_INT: begin
                    if (!as_s) begin
                        state_q <= ST_IDLE;
                        busy_q  <= 1'b0;
                    end else begin
                        state_q   <= ST_ACK;
                        dtack_n_q <= 1'b0;
                    end
                end
                ST_ACK: begin
                    if (!as_s) begin
                        state_q   <= ST_IDLE;
                        dtack_n_q <= 1'b1;
                        re_n_q    <= 1'b1;
                        we_n_q    <= 1'b1;
                        busy_q    <= 1'b0;
                    end
                end
                ST_BERR: begin
                    if (!as_s) begin
                        state_q  <= ST_IDLE;
                        berr_n_q <= 1'b1;
                        busy_q   <= 1'b0;
                    end
                end
                default: begin
                    state_q   <= ST_IDLE;
                    re_n_q    <= 1'b1;
                    we_n_q    <= 1'b1;
                    dtack_n_q <= 1'b1;
                    berr_n_q  <= 1'b1;
                    busy_q    <= 1'b0;
                end
            endcase
        end
    end

    assign re_n    = re_n_q;
    assign we_n    = we_n_q;
    assign dtack_n = dtack_n_q;
    assign berr_n  = berr_n_q;
    assign int_rd  = int_rd_q;
    assign int_wr  = int_wr_q;
    assign busy    = busy_q;

endmodule

// File: tb/tb_bus_cycle_ctrl.sv
// Testbench for bus_cycle_ctrl: directed and random bus cycles
// checked against an edge-timeline model of the cycle rules.
module tb_bus_cycle_ctrl;

    logic sysclk = 1'b0;
    logic sysrst = 1'b1;
    logic as_n = 1'b1, uds_n = 1'b1, lds_n = 1'b1, w_n = 1'b1;
    logic csram1 = 0, csram2 = 0, csrom = 0, csio = 0;
    logic csgfx = 0, csctrl = 0, cspgtbl = 0, csunmap = 0;
    logic io_ready = 1'b0;
    logic re_n, we_n, dtack_n, berr_n, int_rd, int_wr, busy;

    int vecs = 0;
    int errs = 0;

    localparam int S   = 3;
    localparam int TMO = 255;
    localparam int INF = 1 << 30;
    localparam logic [6:0] IDLE_V = 7'b1111000;

    bus_cycle_ctrl dut (
        .sysclk   (sysclk),
        .sysrst   (sysrst),
        .as_n     (as_n),
        .uds_n    (uds_n),
        .lds_n    (lds_n),
        .w_n      (w_n),
        .csram1   (csram1),
        .csram2   (csram2),
        .csrom    (csrom),
        .csio     (csio),
        .csgfx    (csgfx),
        .csctrl   (csctrl),
        .cspgtbl  (cspgtbl),
        .csunmap  (csunmap),
        .io_ready (io_ready),
        .re_n     (re_n),
        .we_n     (we_n),
        .dtack_n  (dtack_n),
        .berr_n   (berr_n),
        .int_rd   (int_rd),
        .int_wr   (int_wr),
        .busy     (busy)
    );

    always #10 sysclk = ~sysclk;

    function automatic int imax(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    task automatic chk(input string tag, input int cyc,
                       input logic [6:0] exp);
        logic [6:0] o;
        o = {re_n, we_n, dtack_n, berr_n, int_rd, int_wr, busy};
        vecs++;
        assert (o === exp) else begin
            errs++;
            $error("FAIL %s cyc=%0d got=%b exp=%b", tag, cyc, o, exp);
        end
    endtask

    task automatic drive_sel(input logic [7:0] s);
        {csunmap, cspgtbl, csctrl, csgfx,
         csio, csrom, csram2, csram1} = s;
    endtask

    // Expected outputs are derived from the edge at which each event of
    // the cycle happens: posedge t is the t-th edge after as_n falls.
    task automatic txn(input string tag, input logic [7:0] sel,
                       input bit wr, input logic [1:0] ds,
                       input int rel, input int qio);
        int w, a, b, e, fin, ackt, berrt, intt;
        bit isberr, isint, str;
        logic [6:0] exp;
        isberr = ($countones(sel) != 1) || sel[7] || (wr && sel[2]);
        isint  = !isberr && (sel[6:4] != 3'b000);
        w      = sel[2] ? 3 : (sel[3] ? 7 : 1);
        e      = rel + 2;
        ackt   = INF;
        berrt  = INF;
        intt   = INF;
        if (isberr) begin
            berrt = S;
            fin   = imax(e, S + 1);
        end else if (isint) begin
            intt = S;
            if (e <= S + 1) begin
                fin = e;
            end else begin
                ackt = S + 1;
                fin  = imax(e, S + 2);
            end
        end else begin
            a = S + w + 1;
            if (sel[3] && qio > a) a = qio;
            b = S + TMO;
            if (e <= a && e <= b) begin
                fin = e;
            end else if (a <= b) begin
                ackt = a;
                fin  = imax(e, a + 1);
            end else begin
                berrt = b;
                fin   = imax(e, b + 1);
            end
        end
        drive_sel(sel);
        w_n = !wr;
        for (int t = 1; t <= fin + 3; t++) begin
            as_n     = !(t < rel);
            uds_n    = !(t < rel && ds[1]);
            lds_n    = !(t < rel && ds[0]);
            io_ready = (t >= qio);
            @(negedge sysclk);
            str = !isberr && !isint && t >= S && t < fin && t < berrt;
            exp[6] = !(str && !wr);
            exp[5] = !(str && wr);
            exp[4] = !(t >= ackt && t < fin);
            exp[3] = !(t >= berrt && t < fin);
            exp[2] = (t == intt) && !wr;
            exp[1] = (t == intt) && wr;
            exp[0] = (t >= S) && (t < fin);
            chk(tag, t, exp);
        end
        drive_sel(8'h00);
        io_ready = 1'b0;
        w_n      = 1'b1;
    endtask

    initial begin
        logic [7:0] s;
        int k;
        sysrst = 1'b1;
        repeat (3) @(negedge sysclk);
        chk("reset", 0, IDLE_V);
        sysrst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge sysclk);
            chk("post_reset_idle", i, IDLE_V);
        end

        txn("ram_read", 8'h01, 1'b0, 2'b01, 10, 1);
        txn("ram2_write", 8'h02, 1'b1, 2'b11, 9, 1);
        txn("rom_read", 8'h04, 1'b0, 2'b10, 12, 1);
        txn("rom_write_berr", 8'h04, 1'b1, 2'b01, 8, 1);
        txn("io_timeout", 8'h08, 1'b1, 2'b01, 265, INF);
        txn("io_ready10", 8'h08, 1'b1, 2'b01, 20, S + 11);
        txn("ctrl_write", 8'h20, 1'b1, 2'b01, 8, 1);
        txn("gfx_read", 8'h10, 1'b0, 2'b11, 9, 1);
        txn("rom_abort", 8'h04, 1'b0, 2'b01, 3, 1);
        txn("int_abort", 8'h40, 1'b0, 2'b01, 2, 1);
        txn("unmap", 8'h80, 1'b0, 2'b01, 6, 1);
        txn("multi_sel", 8'h03, 1'b0, 2'b01, 6, 1);
        txn("no_sel", 8'h00, 1'b1, 2'b01, 6, 1);

        drive_sel(8'h01);
        as_n  = 1'b0;
        lds_n = 1'b0;
        repeat (6) @(negedge sysclk);
        chk("pre_rst_ack", 6, 7'b0101001);
        sysrst = 1'b1;
        #2;
        chk("rst_in_ack", 6, IDLE_V);
        @(negedge sysclk);
        sysrst = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(negedge sysclk);
            chk("held_as_after_rst", i, IDLE_V);
        end
        as_n  = 1'b1;
        lds_n = 1'b1;
        drive_sel(8'h00);
        repeat (4) @(negedge sysclk);
        chk("rst_released", 0, IDLE_V);
        txn("after_rst", 8'h01, 1'b0, 2'b01, 10, 1);

        for (int n = 0; n < 40; n++) begin
            k = $urandom_range(0, 9);
            if (k <= 3) s = 8'h01 << k;
            else if (k <= 6) s = 8'h01 << (k);
            else if (k == 7) s = 8'h80;
            else if (k == 8) s = 8'h01 << $urandom_range(0, 7) | 8'h08;
            else s = 8'h00;
            txn("random", s, 1'($urandom_range(0, 1)),
                2'($urandom_range(1, 3)),
                $urandom_range(2, 20), $urandom_range(1, 25));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
